// File: rtl/pe_mac_unit.sv
// pe_mac_unit: single-lane multiply(-accumulate) processing element.
// One command is accepted in IDLE; MAC takes MUL_LATENCY cycles from accept
// to the one-cycle done pulse, any other opcode completes the next cycle with 0.
// Optional build macro: PE_ACCUMULATE_EN (adds the running accumulator).
// Handshake: a command is taken on a rising clk edge where pe_cmd_valid_i=1 and
// the unit is in IDLE (pe_cmd_ready_o=1); ready is also high in DONE, but DONE
// never samples valid, so the producer should wait one cycle after done.

package nmcu_pkg;
    parameter int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        PE_IDLE = 2'd0,
        PE_BUSY = 2'd1,
        PE_DONE = 2'd2
    } pe_state_e;
endpackage

package instr_pkg;
    typedef enum logic [3:0] {
        INSTR_NOP   = 4'd0,
        INSTR_MAC   = 4'd1,
        INSTR_LOAD  = 4'd2,
        INSTR_STORE = 4'd3
    } opcode_e;

    typedef struct packed {
        opcode_e    opcode;
        logic [7:0] len;
    } instruction_t;
endpackage

module pe_mac_unit
    import nmcu_pkg::*;
    import instr_pkg::*;
#(
    parameter int DATA_WIDTH  = nmcu_pkg::DATA_WIDTH,
    parameter int MUL_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pe_cmd_valid_i,
    input  instruction_t          pe_cmd_i,
    input  logic [DATA_WIDTH-1:0] pe_operand_a_i,
    input  logic [DATA_WIDTH-1:0] pe_operand_b_i,
    output logic                  pe_cmd_ready_o,
    output logic                  pe_done_o,
    output logic [DATA_WIDTH-1:0] pe_result_o,
    output logic                  pe_busy_o,
    output pe_state_e             pe_state_o
);

    pe_state_e             state_q;
    logic [3:0]            cnt_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  done_q;
    logic                  busy_q;
    logic                  ready_q;

    // MAC value for a command taken straight from the inputs (MUL_LATENCY=1)
    // and for the latched command at the end of BUSY.
    logic [DATA_WIDTH-1:0] mac_now_d;
    logic [DATA_WIDTH-1:0] mac_lat_d;

`ifdef PE_ACCUMULATE_EN
    logic [DATA_WIDTH-1:0] acc_q;
    logic [7:0]            len_q;

    // The low DATA_WIDTH bits of the full 2*DATA_WIDTH product are exactly the
    // truncated W-bit product, so only those bits are formed. len==0 starts a
    // fresh accumulation.
    function automatic logic [DATA_WIDTH-1:0] mac_fn(
        input logic [DATA_WIDTH-1:0] acc,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic [7:0]            len
    );
        logic [DATA_WIDTH-1:0] prod;
        prod = a * b;
        return ((len == 8'd0) ? '0 : acc) + prod;
    endfunction

    assign mac_now_d = mac_fn(acc_q, pe_operand_a_i, pe_operand_b_i, pe_cmd_i.len);
    assign mac_lat_d = mac_fn(acc_q, a_q, b_q, len_q);
`else
    function automatic logic [DATA_WIDTH-1:0] mac_fn(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH-1:0] prod;
        prod = a * b;
        return prod;
    endfunction

    assign mac_now_d = mac_fn(pe_operand_a_i, pe_operand_b_i);
    assign mac_lat_d = mac_fn(a_q, b_q);
`endif

    // Control FSM with registered status outputs, operand latch and result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= PE_IDLE;
            cnt_q    <= 4'd0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
`ifdef PE_ACCUMULATE_EN
            acc_q    <= '0;
            len_q    <= 8'd0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                PE_IDLE: begin
                    if (pe_cmd_valid_i) begin
                        a_q <= pe_operand_a_i;
                        b_q <= pe_operand_b_i;
`ifdef PE_ACCUMULATE_EN
                        len_q <= pe_cmd_i.len;
`endif
                        if (pe_cmd_i.opcode == INSTR_MAC) begin
                            if (MUL_LATENCY == 1) begin
                                state_q  <= PE_DONE;
                                done_q   <= 1'b1;
                                result_q <= mac_now_d;
`ifdef PE_ACCUMULATE_EN
                                acc_q    <= mac_now_d;
`endif
                            end else begin
                                state_q <= PE_BUSY;
                                busy_q  <= 1'b1;
                                ready_q <= 1'b0;
                                cnt_q   <= 4'(MUL_LATENCY - 1);
                            end
                        end else begin
                            // Non-MAC opcodes complete at once with a zero result.
                            state_q  <= PE_DONE;
                            done_q   <= 1'b1;
                            result_q <= '0;
                        end
                    end
                end
                PE_BUSY: begin
                    // The counter reaches 0 on this edge: finish the operation.
                    if (cnt_q == 4'd1) begin
                        state_q  <= PE_DONE;
                        cnt_q    <= 4'd0;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        ready_q  <= 1'b1;
                        result_q <= mac_lat_d;
`ifdef PE_ACCUMULATE_EN
                        acc_q    <= mac_lat_d;
`endif
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                PE_DONE: begin
                    state_q <= PE_IDLE;
                end
                default: begin
                    state_q <= PE_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign pe_cmd_ready_o = ready_q;
    assign pe_done_o      = done_q;
    assign pe_busy_o      = busy_q;
    assign pe_result_o    = result_q;
    assign pe_state_o     = state_q;

endmodule

// File: tb/tb_pe_mac_unit.sv
// Bench for pe_mac_unit (DATA_WIDTH=32, MUL_LATENCY=3). Expected results are
// pushed when a command is driven and popped when the unit pulses done.
// Define PE_ACCUMULATE_EN for both bench and RTL to cover the accumulator build.
module tb_pe_mac_unit;
    import nmcu_pkg::*;
    import instr_pkg::*;

    localparam int W = 32;
    localparam int L = 3;

    // Clock and reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         cmd_valid = 1'b0;
    instruction_t cmd;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cmd_ready;
    logic         done;
    logic [W-1:0] result;
    logic         busy;
    pe_state_e    state;

    pe_mac_unit #(.DATA_WIDTH(W), .MUL_LATENCY(L)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pe_cmd_valid_i (cmd_valid),
        .pe_cmd_i       (cmd),
        .pe_operand_a_i (op_a),
        .pe_operand_b_i (op_b),
        .pe_cmd_ready_o (cmd_ready),
        .pe_done_o      (done),
        .pe_result_o    (result),
        .pe_busy_o      (busy),
        .pe_state_o     (state)
    );

    // Scoreboard state
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;
    logic [W-1:0] hold_val = '0;
    logic [W-1:0] acc_m = '0;
    logic         mon_en = 1'b0;
    int           chk_cnt = 0;
    int           err_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every done pops one expected result; otherwise result must hold.
    always @(negedge clk) begin
        if (mon_en) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_done", 64'(done), 64'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check_val("result", 64'(result), 64'(exp_v));
                    hold_val = exp_v;
                end
            end else begin
                check_val("result_hold", 64'(result), 64'(hold_val));
            end
        end
    end

    // Driver: one command, then cycle-accurate status checks up to done.
    // abort=1 asserts reset two cycles after accept.
    task automatic run_op(input opcode_e op, input logic [7:0] len,
                          input logic [W-1:0] a, input logic [W-1:0] b, input bit abort);
        logic [W-1:0]   exp;
        logic [2*W-1:0] prod;
        int             lat;
        prod = 64'(a) * 64'(b);
        lat  = (op == INSTR_MAC) ? L : 1;
        if (op == INSTR_MAC) begin
`ifdef PE_ACCUMULATE_EN
            exp = ((len == 8'd0) ? '0 : acc_m) + prod[W-1:0];
            if (!abort) acc_m = exp;
`else
            exp = prod[W-1:0];
`endif
        end else begin
            exp = '0;
        end
        @(negedge clk);
        check_val("idle_ready", 64'(cmd_ready), 64'd1);
        check_val("idle_busy", 64'(busy), 64'd0);
        check_val("idle_done", 64'(done), 64'd0);
        cmd_valid  = 1'b1;
        cmd.opcode = op;
        cmd.len    = len;
        op_a       = a;
        op_b       = b;
        if (!abort) exp_q.push_back(exp);
        @(posedge clk);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (abort && k == 2) begin
                check_val("abort_busy", 64'(busy), 64'd1);
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                hold_val = '0;
                acc_m    = '0;
                @(negedge clk);
                check_val("abort_state", 64'(state), 64'(PE_IDLE));
                check_val("abort_done", 64'(done), 64'd0);
                check_val("abort_busy_clr", 64'(busy), 64'd0);
                rst_n = 1'b1;
                repeat (L + 2) begin
                    @(negedge clk);
                    check_val("abort_no_done", 64'(done), 64'd0);
                end
                return;
            end else if (k < lat) begin
                check_val("busy_flag", 64'(busy), 64'd1);
                check_val("busy_ready", 64'(cmd_ready), 64'd0);
                check_val("busy_done", 64'(done), 64'd0);
            end else begin
                check_val("done_flag", 64'(done), 64'd1);
                check_val("done_ready", 64'(cmd_ready), 64'd1);
                check_val("done_busy", 64'(busy), 64'd0);
            end
            if (k == 1) begin
                // Drop valid and scramble the inputs: the latched command must win.
                cmd_valid = 1'b0;
                op_a      = $urandom;
                op_b      = $urandom;
                cmd.len   = 8'($urandom_range(0, 255));
            end
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        opcode_e    op;
        logic [7:0] ln;
        cmd = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_result", 64'(result), 64'd0);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_val("idle5_ready", 64'(cmd_ready), 64'd1);
            check_val("idle5_done", 64'(done), 64'd0);
            check_val("idle5_busy", 64'(busy), 64'd0);
            check_val("idle5_result", 64'(result), 64'd0);
        end
        @(posedge clk);
        #1 mon_en = 1'b1;

        run_op(INSTR_MAC, 8'd0, 32'd6, 32'd7, 1'b0);
        run_op(INSTR_MAC, 8'd4, 32'd2, 32'd5, 1'b0);
        run_op(INSTR_MAC, 8'd0, 32'd3, 32'd3, 1'b0);
        run_op(INSTR_NOP, 8'd3, 32'd99, 32'd77, 1'b0);
        run_op(INSTR_MAC, 8'd1, 32'd1, 32'd1, 1'b0);
        run_op(INSTR_MAC, 8'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        run_op(INSTR_MAC, 8'd1, 32'd3, 32'd1, 1'b0);
        run_op(INSTR_MAC, 8'd0, 32'h8000_0001, 32'h8000_0001, 1'b0);

        for (int i = 0; i < 8; i++) begin
            op = (i % 4 == 3) ? INSTR_LOAD : INSTR_MAC;
            ln = 8'($urandom_range(0, 2));
            run_op(op, ln, $urandom, $urandom, 1'b0);
        end

        run_op(INSTR_MAC, 8'd0, 32'd5, 32'd5, 1'b1);
        run_op(INSTR_MAC, 8'd0, 32'd5, 32'd5, 1'b0);
        run_op(INSTR_MAC, 8'd2, 32'd4, 32'd4, 1'b0);

        repeat (3) @(negedge clk);
        check_val("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
